// File: rtl/sram_read_arbiter.sv
// Round-robin arbiter that shares one AXI read port among NREQ burst-read requesters.
// One request is accepted at a time, issued as a single INCR burst, and its R beats are steered back.
module sram_read_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 4,
  parameter int GW   = 2
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*4-1:0] req_len,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_last,
  output logic              err,
  input  logic              err_clr,
  output logic [IDW-1:0]    ARID_M,
  output logic [31:0]       ARADDR_M,
  output logic [3:0]        ARLEN_M,
  output logic [2:0]        ARSIZE_M,
  output logic [1:0]        ARBURST_M,
  output logic              ARVALID_M,
  input  logic              ARREADY_M,
  input  logic [IDW-1:0]    RID_M,
  input  logic [31:0]       RDATA_M,
  input  logic [1:0]        RRESP_M,
  input  logic              RLAST_M,
  input  logic              RVALID_M,
  output logic              RREADY_M
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t         state_reg, state_next;
  logic [GW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [GW-1:0]  grant_reg, grant_next;
  logic [GW-1:0]  grant_sel;
  logic           any_req;
  logic [3:0]     beat_cnt_reg, beat_cnt_next;
  logic [31:0]    addr_reg, addr_next;
  logic [3:0]     len_reg, len_next;
  logic           err_reg, err_next;
  logic           beat;
  logic           beat_err;
  logic [IDW-1:0] id_now;
  int             idx;

  // Lowest rotational offset from rr_ptr wins; scanning downward lets it overwrite.
  always_comb begin
    grant_sel = '0;
    any_req   = 1'b0;
    idx       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        grant_sel = GW'(idx);
        any_req   = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_port
    assign req_ready[gi] = ARESETn && (state_reg == IDLE) && any_req && (grant_sel == GW'(gi));
    assign rsp_valid[gi] = (state_reg == DATA) && RVALID_M && (grant_reg == GW'(gi));
  end

  assign id_now    = IDW'(grant_reg);
  assign ARID_M    = id_now;
  assign ARADDR_M  = addr_reg;
  assign ARLEN_M   = len_reg;
  assign ARSIZE_M  = 3'b010;
  assign ARBURST_M = 2'b01;
  assign ARVALID_M = (state_reg == ADDR);
  assign RREADY_M  = (state_reg == DATA) && rsp_ready[grant_reg];
  assign rsp_data  = RDATA_M;
  assign rsp_last  = (state_reg == DATA) && RVALID_M && RLAST_M;
  assign err       = err_reg;

  assign beat     = (state_reg == DATA) && RVALID_M && RREADY_M;
  // The burst is never cut short on a length mismatch; we only flag it.
  assign beat_err = beat && ((RRESP_M != 2'b00) || (RID_M != id_now) ||
                             (RLAST_M && (beat_cnt_reg != len_reg)) ||
                             (!RLAST_M && (beat_cnt_reg == len_reg)));

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    grant_next    = grant_reg;
    beat_cnt_next = beat_cnt_reg;
    addr_next     = addr_reg;
    len_next      = len_reg;
    err_next      = err_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          grant_next    = grant_sel;
          addr_next     = {req_addr[32*int'(grant_sel)+2 +: 30], 2'b00};
          len_next      = req_len[4*int'(grant_sel) +: 4];
          beat_cnt_next = 4'd0;
          state_next    = ADDR;
        end
      end
      ADDR: begin
        if (ARREADY_M) state_next = DATA;
      end
      DATA: begin
        if (beat) begin
          beat_cnt_next = beat_cnt_reg + 4'd1;
          if (RLAST_M) begin
            state_next  = IDLE;
            rr_ptr_next = (grant_reg == GW'(NREQ - 1)) ? '0 : grant_reg + GW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (beat_err)     err_next = 1'b1;
    else if (err_clr) err_next = 1'b0;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      grant_reg    <= '0;
      beat_cnt_reg <= 4'd0;
      addr_reg     <= 32'd0;
      len_reg      <= 4'd0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      grant_reg    <= grant_next;
      beat_cnt_reg <= beat_cnt_next;
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      err_reg      <= err_next;
    end
  end

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Directed bench for sram_read_arbiter: the bench plays both requesters and the AXI slave.
module tb_sram_read_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0] req_addr;
  logic [7:0]  req_len;
  logic [31:0] rsp_data;
  logic        rsp_last, err, err_clr;
  logic [3:0]  ARID_M, ARLEN_M, RID_M;
  logic [31:0] ARADDR_M, RDATA_M;
  logic [2:0]  ARSIZE_M;
  logic [1:0]  ARBURST_M, RRESP_M;
  logic        ARVALID_M, ARREADY_M, RLAST_M, RVALID_M, RREADY_M;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  sram_read_arbiter #(.NREQ(2), .IDW(4), .GW(2)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .err(err), .err_clr(err_clr),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
    .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Entered at edge+1 in IDLE with the request already driven; leaves at edge+1 back in IDLE.
  task automatic do_burst(input int eg, input logic [31:0] eaddr, input logic [3:0] elen,
                          input int nbeats, input bit hold, input int err_beat,
                          input int stall_beat, input int stall_cycles);
    #1;
    chk("req_ready_grant", {30'd0, req_ready}, 32'd1 << eg);
    tick();
    if (!hold) req_valid[eg] = 1'b0;
    #1;
    chk("arvalid", {31'd0, ARVALID_M}, 32'd1);
    chk("araddr", ARADDR_M, eaddr);
    chk("arlen", {28'd0, ARLEN_M}, {28'd0, elen});
    chk("arid", {28'd0, ARID_M}, eg);
    chk("arsize_burst", {27'd0, ARSIZE_M, ARBURST_M}, {27'd0, 3'b010, 2'b01});
    chk("req_ready_addr", {30'd0, req_ready}, 32'd0);
    ARREADY_M = 1'b1;
    tick();
    ARREADY_M = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      RVALID_M = 1'b1;
      RDATA_M  = 32'hA000_0000 | (eg << 8) | b;
      RLAST_M  = (b == nbeats - 1);
      RID_M    = 4'(eg);
      RRESP_M  = (b == err_beat) ? 2'b10 : 2'b00;
      if (b == stall_beat) begin
        rsp_ready[eg] = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          #1;
          chk("stall_rready", {31'd0, RREADY_M}, 32'd0);
          chk("stall_rsp_valid", {30'd0, rsp_valid}, 32'd1 << eg);
          tick();
        end
        rsp_ready[eg] = 1'b1;
      end
      #1;
      chk("rsp_valid", {30'd0, rsp_valid}, 32'd1 << eg);
      chk("rready", {31'd0, RREADY_M}, 32'd1);
      chk("rsp_data", rsp_data, 32'hA000_0000 | (eg << 8) | b);
      chk("rsp_last", {31'd0, rsp_last}, (b == nbeats - 1) ? 32'd1 : 32'd0);
      chk("req_ready_data", {30'd0, req_ready}, 32'd0);
      tick();
    end
    RVALID_M = 1'b0;
    RLAST_M  = 1'b0;
    RRESP_M  = 2'b00;
    $display("burst grant=%0d addr=%h len=%0d beats=%0d err=%0b", eg, eaddr, elen, nbeats, err);
  endtask

  initial begin
    ARESETn = 1'b0; req_valid = 2'b00; req_addr = '0; req_len = '0; rsp_ready = 2'b11;
    err_clr = 1'b0; ARREADY_M = 1'b0; RID_M = '0; RDATA_M = '0; RRESP_M = '0;
    RLAST_M = 1'b0; RVALID_M = 1'b0;
    #12;
    chk("rst_arvalid", {31'd0, ARVALID_M}, 32'd0);
    chk("rst_rready", {31'd0, RREADY_M}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_araddr", ARADDR_M, 32'd0);
    ARESETn = 1'b1;
    tick();

    // Both requesters held: grants 0,1,0 with one IDLE arbitration cycle between bursts.
    req_valid = 2'b11;
    req_addr  = {32'h0000_0200, 32'h0000_0100};
    req_len   = 8'h00;
    do_burst(0, 32'h100, 4'd0, 1, 1'b1, -1, -1, 0);
    do_burst(1, 32'h200, 4'd0, 1, 1'b1, -1, -1, 0);
    do_burst(0, 32'h100, 4'd0, 1, 1'b1, -1, -1, 0);
    req_valid = 2'b00;

    // Single request, len 3 at 0x104.
    req_addr[31:0] = 32'h0000_0104; req_len[3:0] = 4'd3; req_valid = 2'b01;
    do_burst(0, 32'h104, 4'd3, 4, 1'b0, -1, -1, 0);
    chk("err_clean", {31'd0, err}, 32'd0);

    // Back-pressure on requester 1 for 5 cycles at beat 2.
    req_addr[63:32] = 32'h0000_0300; req_len[7:4] = 4'd3; req_valid = 2'b10;
    do_burst(1, 32'h300, 4'd3, 4, 1'b0, -1, 1, 5);
    chk("err_after_stall", {31'd0, err}, 32'd0);

    // SLVERR on beat 2 sets sticky err.
    req_addr[31:0] = 32'h0000_0400; req_len[3:0] = 4'd3; req_valid = 2'b01;
    do_burst(0, 32'h400, 4'd3, 4, 1'b0, 1, -1, 0);
    chk("err_resp_sticky", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", {31'd0, err}, 32'd0);

    // Early RLAST on beat 2 of a len-3 burst.
    req_valid = 2'b01;
    do_burst(0, 32'h400, 4'd3, 2, 1'b0, -1, -1, 0);
    chk("err_early_last", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared2", {31'd0, err}, 32'd0);

    // Unaligned address is forced to a word boundary.
    req_addr[31:0] = 32'h0000_0007; req_len[3:0] = 4'd0; req_valid = 2'b01;
    do_burst(0, 32'h4, 4'd0, 1, 1'b0, -1, -1, 0);

    // Reset during beat 2 of a requester-1 burst (rr_ptr is 1 here).
    req_addr[63:32] = 32'h0000_0500; req_len[7:4] = 4'd3; req_valid = 2'b10;
    #1;
    chk("rst_test_grant", {30'd0, req_ready}, 32'd2);
    tick();
    req_valid = 2'b00;
    ARREADY_M = 1'b1;
    tick();
    ARREADY_M = 1'b0;
    RVALID_M = 1'b1; RID_M = 4'd1; RRESP_M = 2'b10; RDATA_M = 32'h55;
    tick();
    RRESP_M = 2'b00;
    #1;
    chk("pre_rst_err", {31'd0, err}, 32'd1);
    chk("pre_rst_rsp_valid", {30'd0, rsp_valid}, 32'd2);
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_arvalid", {31'd0, ARVALID_M}, 32'd0);
    chk("mid_rst_rready", {31'd0, RREADY_M}, 32'd0);
    chk("mid_rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    RVALID_M = 1'b0;
    tick();
    ARESETn = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("post_rst_grant", {30'd0, req_ready}, 32'd1);
    $display("reset mid-burst checked, first grant after release=%b", req_ready);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
